dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have parameter: MEM, 10, RAM word-address width (depth 2^MEM words of 32 bits).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req_valid  input  1  request present.
REQ-005 SHALL have port: req_ready  output  1  request accepted when req_valid&&req_ready at clk edge.
REQ-006 SHALL have port: req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port: req_addr  input  32  byte address.
REQ-008 SHALL have port: req_wdata  input  32  store data.
REQ-009 SHALL have port: req_wstrb  input  4  store byte enables, bit i = byte lane i (bits 8i+7:8i).
REQ-010 SHALL have port: rsp_valid  output  1  response present.
REQ-011 SHALL have port: rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready at clk edge.
REQ-012 SHALL have port: rsp_rdata  output  32  load data; 0 for stores.
REQ-013 SHALL have ports to RAM: ram_we out 1, ram_addr out MEM, ram_din out 32, ram_dout in 32; RAM is synchronous, 1-cycle read latency, read-before-write.

Function
REQ-014 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RMW_RD, RMW_WAIT, RMW_WR, RESP.
REQ-015 SHALL assert req_ready only in IDLE; one transaction outstanding, no pipelining.
REQ-016 SHALL latch req_we/addr/wdata/wstrb at acceptance; later input changes have no effect.
REQ-017 SHALL drive ram_addr = latched req_addr[MEM+1:2]; addr[1:0] ignored, bits above MEM+1 ignored (wrap).
REQ-018 SHALL route on accept: load -> RD_ISSUE; store with wstrb=4'hF or 4'h0 -> WR_ISSUE; other wstrb -> RMW_RD.
REQ-019 SHALL for loads: RD_ISSUE -> RD_WAIT -> RESP, capturing ram_dout into rsp_rdata at RD_WAIT exit; rsp_valid high 3 cycles after accept edge.
REQ-020 SHALL for full stores: WR_ISSUE drives ram_we=1, ram_din=wdata for exactly one cycle, then RESP; rsp_valid high 2 cycles after accept.
REQ-021 SHALL treat wstrb=4'h0 store as no-op: WR_ISSUE with ram_we=0, same timing as REQ-020.
REQ-022 SHALL for partial stores: RMW_RD (read) -> RMW_WAIT (capture ram_dout) -> RMW_WR (ram_we=1, ram_din = per-lane wdata if wstrb[i] else captured old byte) -> RESP; rsp_valid high 4 cycles after accept.
REQ-023 SHALL keep ram_we=0 in every state except WR_ISSUE (wstrb!=0) and RMW_WR.
REQ-024 SHALL hold rsp_valid and rsp_rdata stable in RESP until rsp_ready; RESP -> IDLE on rsp_ready.
REQ-025 SHALL set rsp_rdata=0 for store responses.

Reset
REQ-026 SHALL on rstn low, immediately and asynchronously: state=IDLE, ram_we=0, rsp_valid=0, rsp_rdata=0, ram_addr=0, ram_din=0, latched request cleared.
REQ-027 SHALL on reset during any state abandon the transaction: no RAM write occurs, no response issued.
REQ-028 SHALL assert req_ready=1 in the first cycle after rstn deasserts.

Structure
REQ-029 SHALL place state enum, STRB_FULL=4'hF, STRB_NONE=4'h0 and default MEM in shared package dmem_pkg.
REQ-030 SHALL implement the lane merge as combinational sub-module byte_merge (old, new, strb -> merged).

Verification
REQ-031 SHALL be verified against the team's single-port synchronous RAM model (read-before-write, 1-cycle read).
REQ-032 SHALL cover: load addr 0x10 with RAM[4]=0xDEADBEEF -> rsp_valid at accept+3, rsp_rdata=0xDEADBEEF.
REQ-033 SHALL cover: store 0x12345678, wstrb F, addr 0x20, then load 0x20 -> ram_we one cycle, load returns 0x12345678.
REQ-034 SHALL cover: RAM[1]=0xAABBCCDD, store 0x00001100 wstrb 4'b0010 addr 0x4 -> RAM[1]=0xAABB11DD, rsp at accept+4.
REQ-035 SHALL cover: rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_rdata constant, req_ready=0, then IDLE after handshake.
REQ-036 SHALL cover: rstn pulsed low during RMW_WAIT -> no ram_we pulse, rsp_valid=0, RAM word unchanged.
REQ-037 SHALL cover: addr 0x1003 with MEM=10 -> ram_addr=0x000 (wrap, low bits ignored).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

    localparam int MEM_DEFAULT = 10;

    localparam logic [3:0] STRB_FULL = 4'hF;
    localparam logic [3:0] STRB_NONE = 4'h0;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RMW_RD,
        RMW_WAIT,
        RMW_WR,
        RESP
    } state_t;

endpackage

// File: rtl/byte_merge.sv
// Combinational byte-lane merge: lanes with strb set take new_data, others keep old_data.
module byte_merge (
    input  logic [31:0] old_data,
    input  logic [31:0] new_data,
    input  logic [3:0]  strb,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-outstanding load/store controller in front of a 1-cycle synchronous RAM,
// with read-modify-write for partial byte-enable stores.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM = MEM_DEFAULT
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [31:0]    req_addr,
    input  logic [31:0]    req_wdata,
    input  logic [3:0]     req_wstrb,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [31:0]    rsp_rdata,
    output logic           ram_we,
    output logic [MEM-1:0] ram_addr,
    output logic [31:0]    ram_din,
    input  logic [31:0]    ram_dout
);

    state_t      state;
    state_t      next_state;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] merged;
    logic        accept;
    logic        full_store;
    logic        unused_addr_bits;

    // Byte offset and bits above the RAM depth are dropped, so addresses wrap.
    assign unused_addr_bits = ^{req_addr[31:MEM+2], req_addr[1:0]};

    assign accept     = (state == IDLE) && req_valid;
    assign full_store = (req_wstrb == STRB_FULL) || (req_wstrb == STRB_NONE);

    byte_merge u_byte_merge (
        .old_data (ram_dout),
        .new_data (wdata_q),
        .strb     (wstrb_q),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!req_we) begin
                        next_state = RD_ISSUE;
                    end else if (full_store) begin
                        next_state = WR_ISSUE;
                    end else begin
                        next_state = RMW_RD;
                    end
                end
            end
            RD_ISSUE: next_state = RD_WAIT;
            RD_WAIT:  next_state = RESP;
            WR_ISSUE: next_state = RESP;
            RMW_RD:   next_state = RMW_WAIT;
            RMW_WAIT: next_state = RMW_WR;
            RMW_WR:   next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default:  next_state = IDLE;
        endcase
    end

    // RAM controls are registered so each is valid for the whole state that owns it;
    // ram_we is cleared every cycle unless the upcoming state is a write state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ram_addr <= req_addr[MEM+1:2];
                        wdata_q  <= req_wdata;
                        wstrb_q  <= req_wstrb;
                        ram_din  <= req_wdata;
                        ram_we   <= req_we && (req_wstrb == STRB_FULL);
                    end
                end
                RD_WAIT: begin
                    rsp_rdata <= ram_dout;
                    rsp_valid <= 1'b1;
                end
                WR_ISSUE: begin
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                end
                RMW_WAIT: begin
                    ram_din <= merged;
                    ram_we  <= 1'b1;
                end
                RMW_WR: begin
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl with a read-before-write RAM model.
module tb_dmem_access_ctrl;

    localparam int MEM = 10;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [31:0]    req_addr = '0;
    logic [31:0]    req_wdata = '0;
    logic [3:0]     req_wstrb = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [31:0]    rsp_rdata;
    logic           ram_we;
    logic [MEM-1:0] ram_addr;
    logic [31:0]    ram_din;
    logic [31:0]    ram_dout = '0;

    int errors = 0;
    int checks = 0;
    int we_pulses = 0;

    logic [31:0] mem [0:(1<<MEM)-1];

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEM(MEM)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Single-port RAM: read data is the pre-write contents, one cycle later.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we) begin
            mem[ram_addr] = ram_din;
            we_pulses++;
        end
    end

    // Drives one request through its accept edge, then scrambles the inputs.
    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        req_wstrb = ~strb;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, ram_we, ram_addr, ram_din, rsp_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rsp_valid=%0b ram_we=%0b ram_addr=%h ram_din=%h rsp_rdata=%h required all 0",
                     rsp_valid, ram_we, ram_addr, ram_din, rsp_rdata);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: req_ready=%0b required 1", req_ready);
        end
    endtask

    task automatic test_load();
        int lat;
        mem[4] = 32'hDEADBEEF;
        send_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        wait_rsp(lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL load_latency: got %0d required 3", lat);
        end
        checks++;
        if (rsp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL load_data: got %h required deadbeef", rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_full_store();
        int lat;
        int we_before;
        we_before = we_pulses;
        send_req(1'b1, 32'h0000_0020, 32'h12345678, 4'hF);
        wait_rsp(lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL store_latency: got %0d required 2", lat);
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL store_rdata: got %h required 00000000", rsp_rdata);
        end
        take_rsp();
        checks++;
        if (we_pulses - we_before !== 1) begin
            errors++;
            $display("[TB] FAIL store_we_pulses: got %0d required 1", we_pulses - we_before);
        end
        send_req(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        wait_rsp(lat);
        checks++;
        if (rsp_rdata !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL store_readback: got %h required 12345678", rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_partial_store();
        int lat;
        int we_before;
        mem[1] = 32'hAABBCCDD;
        we_before = we_pulses;
        send_req(1'b1, 32'h0000_0004, 32'h00001100, 4'b0010);
        wait_rsp(lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL rmw_latency: got %0d required 4", lat);
        end
        take_rsp();
        checks++;
        if (mem[1] !== 32'hAABB11DD) begin
            errors++;
            $display("[TB] FAIL rmw_result: got %h required aabb11dd", mem[1]);
        end
        checks++;
        if (we_pulses - we_before !== 1) begin
            errors++;
            $display("[TB] FAIL rmw_we_pulses: got %0d required 1", we_pulses - we_before);
        end
    endtask

    task automatic test_noop_store();
        int lat;
        int we_before;
        mem[2] = 32'h11223344;
        we_before = we_pulses;
        send_req(1'b1, 32'h0000_0008, 32'hFFFFFFFF, 4'h0);
        wait_rsp(lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL noop_latency: got %0d required 2", lat);
        end
        take_rsp();
        checks++;
        if (we_pulses != we_before || mem[2] !== 32'h11223344) begin
            errors++;
            $display("[TB] FAIL noop_store: pulses=%0d mem=%h required 0 and 11223344",
                     we_pulses - we_before, mem[2]);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        mem[6] = 32'h0BADF00D;
        send_req(1'b0, 32'h0000_0018, 32'h0, 4'h0);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADF00D || req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_resp[%0d]: valid=%0b rdata=%h ready=%0b required 1 0badf00d 0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        req_valid = 1'b0;
        take_rsp();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_hs: req_ready=%0b rsp_valid=%0b required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int we_before;
        mem[5] = 32'h55667788;
        we_before = we_pulses;
        send_req(1'b1, 32'h0000_0014, 32'h000000EE, 4'b0001);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b0 || rsp_valid !== 1'b0 || ram_addr !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: ram_we=%0b rsp_valid=%0b ram_addr=%h required 0 0 000",
                     ram_we, rsp_valid, ram_addr);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_abort: req_ready=%0b required 1", req_ready);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (we_pulses != we_before || mem[5] !== 32'h55667788 || rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_rmw: pulses=%0d mem=%h rsp_valid=%0b required 0 55667788 0",
                     we_pulses - we_before, mem[5], rsp_valid);
        end
    endtask

    task automatic test_wrap();
        int lat;
        mem[0] = 32'hCAFEF00D;
        send_req(1'b0, 32'h0000_1003, 32'h0, 4'h0);
        checks++;
        if (ram_addr !== 10'h000) begin
            errors++;
            $display("[TB] FAIL wrap_addr: got %h required 000", ram_addr);
        end
        wait_rsp(lat);
        checks++;
        if (rsp_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("[TB] FAIL wrap_data: got %h required cafef00d", rsp_rdata);
        end
        take_rsp();
    endtask

    initial begin
        for (int i = 0; i < (1 << MEM); i++) begin
            mem[i] = 32'h0;
        end
        test_reset();
        test_load();
        test_full_store();
        test_partial_store();
        test_noop_store();
        test_backpressure();
        test_reset_mid_rmw();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
